// File: rtl/reduce_pkg.sv
// Shared opcode encoding, reduction families, identity values and FSM states
// for the two-requester reduce arbiter.
package reduce_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        FAM_AND = 2'd0,
        FAM_OR  = 2'd1,
        FAM_XOR = 2'd2
    } family_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic ID_AND = 1'b1;
    localparam logic ID_OR  = 1'b0;
    localparam logic ID_XOR = 1'b0;

    function automatic family_t op_family(input logic [2:0] op);
        case (op)
            OP_AND, OP_NAND: return FAM_AND;
            OP_OR, OP_NOR:   return FAM_OR;
            default:         return FAM_XOR;
        endcase
    endfunction

    function automatic logic fam_identity(input family_t fam);
        case (fam)
            FAM_AND: return ID_AND;
            FAM_OR:  return ID_OR;
            default: return ID_XOR;
        endcase
    endfunction

    function automatic logic fam_combine(input family_t fam, input logic a, input logic b);
        case (fam)
            FAM_AND: return a & b;
            FAM_OR:  return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic op_inverts(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    // Opcodes 6 and 7 run through the datapath but always report 0.
    function automatic logic op_reserved(input logic [2:0] op);
        return op > OP_XNOR;
    endfunction

endpackage

// File: rtl/reduce_slice.sv
// Combinational reduction of one SLICE-bit chunk using the selected family operator.
module reduce_slice
    import reduce_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_operand,
    input  logic [1:0]       i_family,
    output logic             o_result
);

    always_comb begin
        o_result = 1'b0;
        case (family_t'(i_family))
            FAM_AND: o_result = &i_operand;
            FAM_OR:  o_result = |i_operand;
            default: o_result = ^i_operand;
        endcase
    end

endmodule

// File: rtl/reduce_arbiter.sv
// Two-requester round-robin arbiter feeding a shared slice-serial bit reducer;
// one operation in flight, result held until the consumer takes it.
module reduce_arbiter
    import reduce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST_K = CW'(NS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_op;
    logic             r_id;
    logic             r_last_grant;
    logic             r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_rsp_valid;
    logic             r_rsp_data;
    logic             r_rsp_id;
    logic             r_busy;

    logic             w_idle;
    logic             w_pick1;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic [2:0]       w_sel_op;
    family_t          w_family;
    logic             w_slice;
    logic             w_acc_next;

    // Ties go to the requester that was not granted last; ready is gated by reset.
    assign w_idle     = (r_state == ST_IDLE) && !RESET;
    assign w_pick1    = req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept   = w_idle && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_pick1;
    assign req1_ready = w_accept && w_pick1;
    assign w_sel_data = w_pick1 ? req1_data : req0_data;
    assign w_sel_op   = w_pick1 ? req1_op : req0_op;

    assign w_family   = op_family(r_op);
    assign w_acc_next = fam_combine(w_family, r_acc, w_slice);

    // The operand register shifts right, so the low slice is always the current one.
    reduce_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_operand (r_data[SLICE-1:0]),
        .i_family  (w_family),
        .o_result  (w_slice)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_acc        <= 1'b0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data       <= w_sel_data;
                        r_op         <= w_sel_op;
                        r_id         <= w_pick1;
                        r_last_grant <= w_pick1;
                        r_acc        <= fam_identity(op_family(w_sel_op));
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_data <= r_data >> SLICE;
                    r_acc  <= w_acc_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_K) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= op_reserved(r_op) ? 1'b0 : (w_acc_next ^ op_inverts(r_op));
                        r_rsp_id    <= r_id;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_reduce_arbiter.sv
// Self-checking bench for reduce_arbiter: directed cases plus randomized
// transactions compared against whole-word reduction and round-robin model.
module tb_reduce_arbiter;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int NS    = WIDTH / SLICE;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [2:0]       req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [2:0]       req1_op;
    logic             rsp_valid, rsp_ready, rsp_data, rsp_id, busy;

    int n_vec = 0;
    int n_mis = 0;
    bit m_last = 1'b1;

    reduce_arbiter #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic model_result(input logic [WIDTH-1:0] d, input logic [2:0] op);
        case (op)
            3'd0:    return &d;
            3'd1:    return ~(&d);
            3'd2:    return |d;
            3'd3:    return ~(|d);
            3'd4:    return ^d;
            3'd5:    return ~(^d);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick_data();
        logic [WIDTH-1:0] one;
        one = 1;
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return '0;
            2:       return ~(one << $urandom_range(0, WIDTH - 1));
            3:       return one << $urandom_range(0, WIDTH - 1);
            default: return WIDTH'($urandom());
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        m_last = 1'b1;
    endtask

    // Presents a request, waits for a grant, then for rsp_valid (rsp_ready held low).
    task automatic issue(input bit both, input bit who,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input logic [2:0] o0, input logic [2:0] o1,
                         output bit g_id, output bit two_ready, output int lat,
                         output bit timed_out);
        int n;
        req0_data = d0; req0_op = o0;
        req1_data = d1; req1_op = o1;
        req0_valid = both || !who;
        req1_valid = both || who;
        timed_out = 1'b0; two_ready = 1'b0; g_id = 1'b0; lat = 0;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge CLK); #1; n++;
        end
        if (!(req0_ready || req1_ready)) begin
            timed_out = 1'b1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        g_id = req1_ready;
        two_ready = req0_ready && req1_ready;
        @(negedge CLK);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge CLK); #1; lat++;
        end
        if (!rsp_valid) timed_out = 1'b1;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = '1; req1_data = '0; req0_op = 3'd0; req1_op = 3'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        n_vec++;
        if ({rsp_valid, rsp_data, rsp_id, busy} !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b expected 0000", {rsp_valid, rsp_data, rsp_id, busy});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_directed();
        bit               t_who[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [WIDTH-1:0] t_data[6] = '{32'hFFFF_FFFF, 32'hFFFF_FF7F, 32'h0000_0000,
                                        32'h0000_0007, 32'h8000_0001, 32'hFFFF_FFFF};
        logic [2:0]       t_op[6]   = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd5, 3'd7};
        logic             t_exp[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit g, two, to;
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, t_who[i], t_data[i], t_data[i], t_op[i], t_op[i], g, two, lat, to);
            n_vec++;
            if (to) begin
                n_mis++;
                $display("FAIL directed_timeout[%0d]: got no response expected response", i);
            end else begin
                n_vec++;
                if (rsp_data !== t_exp[i]) begin
                    n_mis++;
                    $display("FAIL directed_data[%0d]: got %b expected %b", i, rsp_data, t_exp[i]);
                end
                n_vec++;
                if (rsp_id !== t_who[i]) begin
                    n_mis++;
                    $display("FAIL directed_id[%0d]: got %b expected %b", i, rsp_id, t_who[i]);
                end
                n_vec++;
                if (lat != NS + 1) begin
                    n_mis++;
                    $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NS + 1);
                end
            end
            m_last = t_who[i];
            release_rsp();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d;
        logic [2:0]       op;
        logic             exp;
        bit g, two, to;
        int lat;
        d = pick_data();
        op = 3'($urandom_range(0, 5));
        exp = model_result(d, op);
        issue(1'b0, 1'b0, d, d, op, op, g, two, lat, to);
        m_last = 1'b0;
        n_vec++;
        if (to) begin
            n_mis++;
            $display("FAIL backpressure_timeout: got no response expected response");
            release_rsp();
            return;
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = ~d; req1_data = ~d;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp, 1'b0}) begin
                n_mis++;
                $display("FAIL backpressure_hold[%0d]: got v/d/id %b expected %b",
                         i, {rsp_valid, rsp_data, rsp_id}, {1'b1, exp, 1'b0});
            end
            n_vec++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_mis++;
                $display("FAIL backpressure_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready});
            end
            @(negedge CLK); #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_mis++;
            $display("FAIL backpressure_handshake_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        @(negedge CLK); #1;
        rsp_ready = 1'b0;
        n_vec++;
        if ({req0_ready, req1_ready, rsp_valid} !== 3'b010) begin
            n_mis++;
            $display("FAIL backpressure_next_grant: got r0/r1/v %b expected 010",
                     {req0_ready, req1_ready, rsp_valid});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d0, d1;
        logic [2:0]       o0, o1;
        bit both, who, win, g, two, to;
        logic exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            both = 1'($urandom_range(0, 1));
            who  = 1'($urandom_range(0, 1));
            d0 = pick_data(); d1 = pick_data();
            o0 = 3'($urandom_range(0, 7)); o1 = 3'($urandom_range(0, 7));
            win = both ? !m_last : who;
            exp = win ? model_result(d1, o1) : model_result(d0, o0);
            issue(both, who, d0, d1, o0, o1, g, two, lat, to);
            n_vec++;
            if (to) begin
                n_mis++;
                $display("FAIL random_timeout[%0d]: got no response expected response", i);
            end else begin
                n_vec++;
                if (g !== win || two) begin
                    n_mis++;
                    $display("FAIL random_grant[%0d]: got %b (both=%b) expected %b", i, g, two, win);
                end
                n_vec++;
                if ({rsp_data, rsp_id} !== {exp, win}) begin
                    n_mis++;
                    $display("FAIL random_rsp[%0d]: got data/id %b expected %b op0=%0d op1=%0d d0=%h d1=%h",
                             i, {rsp_data, rsp_id}, {exp, win}, o0, o1, d0, d1);
                end
                n_vec++;
                if (lat != NS + 1) begin
                    n_mis++;
                    $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, NS + 1);
                end
            end
            m_last = win;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            release_rsp();
        end
    endtask

    task automatic test_reset_in_run();
        logic [WIDTH-1:0] d0, d1;
        logic [2:0]       o0, o1;
        bit g, two, to, seen;
        int lat;
        @(negedge CLK);
        req0_data = '1; req0_op = 3'd0; req0_valid = 1'b1;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL rir_accept: got %b expected 1", req0_ready);
        end
        @(negedge CLK);
        req0_valid = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_mis++;
            $display("FAIL rir_ready_in_reset: got %b expected 00", {req0_ready, req1_ready});
        end
        @(negedge CLK);
        RESET = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        m_last = 1'b1;
        seen = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL rir_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge CLK); #1;
        end
        n_vec++;
        if (seen) begin
            n_mis++;
            $display("FAIL rir_no_response: got response expected none");
        end
        d0 = pick_data(); d1 = pick_data();
        o0 = 3'($urandom_range(0, 5)); o1 = 3'($urandom_range(0, 5));
        issue(1'b1, 1'b0, d0, d1, o0, o1, g, two, lat, to);
        n_vec++;
        if (to || g !== 1'b0 || {rsp_data, rsp_id} !== {model_result(d0, o0), 1'b0}) begin
            n_mis++;
            $display("FAIL rir_after_reset: got to/grant/data/id %b expected 0 0 %b 0",
                     {to, g, rsp_data, rsp_id}, model_result(d0, o0));
        end
        m_last = 1'b0;
        release_rsp();
    endtask

    task automatic test_alternate();
        logic [WIDTH-1:0] d0, d1;
        logic [2:0]       o0, o1;
        bit   grants[$];
        bit   rids[$];
        logic rdata[$];
        int   gcyc[$];
        bit   exp_g;
        apply_reset();
        d0 = pick_data(); d1 = pick_data();
        o0 = 3'($urandom_range(0, 5)); o1 = 3'($urandom_range(0, 5));
        req0_data = d0; req0_op = o0; req1_data = d1; req1_op = o1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 80 && rids.size() < 4; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                grants.push_back(req1_ready);
                gcyc.push_back(c);
                n_vec++;
                if (req0_ready && req1_ready) begin
                    n_mis++;
                    $display("FAIL alt_single_grant: got 11 expected one-hot");
                end
            end
            if (rsp_valid) begin
                rids.push_back(rsp_id);
                rdata.push_back(rsp_data);
            end
            if (rids.size() == 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            @(negedge CLK);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b0;
        n_vec++;
        if (rids.size() != 4 || grants.size() != 4) begin
            n_mis++;
            $display("FAIL alt_count: got %0d responses %0d grants expected 4 and 4",
                     rids.size(), grants.size());
            return;
        end
        exp_g = !m_last;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (grants[i] !== exp_g || rids[i] !== exp_g) begin
                n_mis++;
                $display("FAIL alt_order[%0d]: got grant %b id %b expected %b", i, grants[i], rids[i], exp_g);
            end
            n_vec++;
            if (rdata[i] !== (exp_g ? model_result(d1, o1) : model_result(d0, o0))) begin
                n_mis++;
                $display("FAIL alt_data[%0d]: got %b expected %b", i, rdata[i],
                         exp_g ? model_result(d1, o1) : model_result(d0, o0));
            end
            if (i > 0) begin
                n_vec++;
                if (gcyc[i] - gcyc[i-1] != NS + 2) begin
                    n_mis++;
                    $display("FAIL alt_spacing[%0d]: got %0d expected %0d", i, gcyc[i] - gcyc[i-1], NS + 2);
                end
            end
            m_last = exp_g;
            exp_g = !exp_g;
        end
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_op = '0; req1_op = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_in_run();
        test_alternate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
